// File: rtl/dmem_pkg.sv
// Shared encodings for the byte-lane data memory.
// Parity storage is enabled with `define DMEM_PARITY_EN.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_ILL  = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store enables/replication, load extract/extend.
// Purely combinational; shared by the store and load paths.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  off_i,
   input  logic        uns_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] raw_i,
   output logic [3:0]  be_o,
   output logic [31:0] wlane_o,
   output logic [31:0] ldata_o,
   output logic        mis_o
);

   logic [31:0] shifted;

   assign shifted = raw_i >> {off_i, 3'b000};

   always_comb begin
      be_o    = 4'b0000;
      wlane_o = wdata_i;
      ldata_o = '0;
      mis_o   = 1'b0;
      unique case (size_i)
         SZ_BYTE: begin
            be_o    = 4'b0001 << off_i;
            wlane_o = {4{wdata_i[7:0]}};
            ldata_o = {{24{~uns_i & shifted[7]}}, shifted[7:0]};
         end
         SZ_HALF: begin
            mis_o   = off_i[0];
            be_o    = off_i[1] ? 4'b1100 : 4'b0011;
            wlane_o = {2{wdata_i[15:0]}};
            ldata_o = {{16{~uns_i & shifted[15]}}, shifted[15:0]};
         end
         SZ_WORD: begin
            mis_o   = |off_i;
            be_o    = 4'b1111;
            ldata_o = raw_i;
         end
         default: mis_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-addressable data memory with registered reads and a clear engine.
// Optional per-lane even parity under `define DMEM_PARITY_EN.
module dmem_bytelane
   import dmem_pkg::*;
#(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [1:0]        size,
   input  logic              uns,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              rvalid,
   output logic              misalign,
   output logic              busy,
   output logic              parity_err
);

   localparam int IW = clog2(DEPTH);

   logic [31:0] mem_q [DEPTH];

   state_e          state_q, state_d;
   logic [IW-1:0]   clr_q, clr_d;
   logic [IW-1:0]   idx;
   logic [31:0]     raw;
   logic [3:0]      be;
   logic [31:0]     wlane;
   logic [31:0]     ldata;
   logic            mis;
   logic            ready;
   logic            acc_ld;
   logic            acc_st;
   logic            perr;
   logic [31:0]     rdata_q;
   logic            rvalid_q, mis_q, perr_q;

   assign idx    = addr[IW+1:2];
   assign raw    = mem_q[idx];
   assign ready  = (state_q == ST_READY);
   assign acc_ld = ready & req & ~we;
   assign acc_st = ready & req & we & ~mis;

   if (ADDR_W > IW + 2) begin : g_hi
      logic unused_hi;
      assign unused_hi = ^addr[ADDR_W-1:IW+2];
   end

   dmem_lane_align u_align (
      .size_i  (size),
      .off_i   (addr[1:0]),
      .uns_i   (uns),
      .wdata_i (wdata),
      .raw_i   (raw),
      .be_o    (be),
      .wlane_o (wlane),
      .ldata_o (ldata),
      .mis_o   (mis)
   );

   always_comb begin
      state_d = state_q;
      clr_d   = clr_q;
      unique case (state_q)
         ST_CLEAR: begin
            clr_d = clr_q + 1'b1;
            if (clr_q == IW'(DEPTH - 1)) state_d = ST_READY;
         end
         ST_READY: state_d = ST_READY;
      endcase
   end

   // No reset on the array so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         mem_q[clr_q] <= '0;
      end else if (acc_st) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) mem_q[idx][8*l +: 8] <= wlane[8*l +: 8];
         end
      end
   end

`ifdef DMEM_PARITY_EN
   logic [3:0] par_q [DEPTH];
   logic [3:0] par_rd;

   always_comb begin
      for (int l = 0; l < 4; l++) par_rd[l] = ^raw[8*l +: 8];
   end

   assign perr = |(be & (par_q[idx] ^ par_rd));

   always_ff @(posedge clk) begin
      if (state_q == ST_CLEAR) begin
         par_q[clr_q] <= 4'b0000;
      end else if (acc_st) begin
         for (int l = 0; l < 4; l++) begin
            if (be[l]) par_q[idx][l] <= ^wlane[8*l +: 8];
         end
      end
   end
`else
   assign perr = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_CLEAR;
         clr_q    <= '0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
         mis_q    <= 1'b0;
         perr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         clr_q    <= clr_d;
         rvalid_q <= acc_ld;
         mis_q    <= ready & req & mis;
         perr_q   <= acc_ld & ~mis & perr;
         if (acc_ld) rdata_q <= mis ? 32'h0 : ldata;
      end
   end

   assign rdata      = rdata_q;
   assign rvalid     = rvalid_q;
   assign misalign   = mis_q;
   assign parity_err = perr_q;
   assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dmem_bytelane.sv
// Scoreboard bench for dmem_bytelane (DEPTH=16) against a byte-array model.
// Define DMEM_PARITY_EN to also exercise the parity path.
module tb_dmem_bytelane;

   localparam int DEPTH = 16;
   localparam int NB    = DEPTH * 4;

   logic        clk;
   logic        rst_n;
   logic        req;
   logic        we;
   logic [1:0]  size;
   logic        uns;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        rvalid;
   logic        misalign;
   logic        busy;
   logic        parity_err;

   dmem_bytelane #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .we         (we),
      .size       (size),
      .uns        (uns),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .rvalid     (rvalid),
      .misalign   (misalign),
      .busy       (busy),
      .parity_err (parity_err)
   );

   typedef struct {
      int          due;
      logic        rv;
      logic        mis;
      logic [31:0] rd;
      logic        pe;
   } exp_t;

   exp_t        q[$];
   logic [7:0]  mem_m [NB];
   logic        bad_m [NB];
   logic [31:0] last_rd;
   int          ncyc;
   int          n_cmp;
   int          n_bad;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] mdl_load(input int a, input int nb,
                                            input logic u);
      logic [31:0] v;
      v = 0;
      for (int k = 0; k < nb; k++) v |= 32'(mem_m[a + k]) << (8 * k);
      if (!u && nb < 4 && v[8*nb-1]) v |= ~((32'd1 << (8 * nb)) - 1);
      return v;
   endfunction

   always @(negedge clk) begin
      exp_t e;
      ncyc++;
      if (q.size() > 0 && q[0].due == ncyc) begin
         e = q.pop_front();
         chk("rvalid", 32'(rvalid), 32'(e.rv));
         chk("misalign", 32'(misalign), 32'(e.mis));
         chk("parity_err", 32'(parity_err), 32'(e.pe));
         if (e.rv) begin
            chk("rdata", rdata, e.rd);
            last_rd = e.rd;
         end else begin
            chk("rdata_hold", rdata, last_rd);
         end
      end else begin
         chk("idle_rvalid", 32'(rvalid), 32'h0);
         chk("idle_misalign", 32'(misalign), 32'h0);
         chk("idle_parity", 32'(parity_err), 32'h0);
         chk("idle_rdata_hold", rdata, last_rd);
      end
   end

   task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] ad, input logic [31:0] wd);
      exp_t e;
      int   a;
      int   nb;
      logic m;
      @(negedge clk);
      #1;
      req   = 1'b1;
      we    = w;
      size  = sz;
      uns   = u;
      addr  = ad;
      wdata = wd;
      a  = int'(ad[5:0]);
      nb = 1 << sz;
      m  = (sz == 2'd3) || (sz == 2'd1 && a % 2 != 0) ||
           (sz == 2'd2 && a % 4 != 0);
      e.due = ncyc + 1;
      e.rv  = !w;
      e.mis = m;
      e.rd  = 0;
      e.pe  = 1'b0;
      if (!w && !m) begin
         e.rd = mdl_load(a, nb, u);
         for (int k = 0; k < nb; k++) e.pe |= bad_m[a + k];
      end
      if (w && !m) begin
         for (int k = 0; k < nb; k++) begin
            mem_m[a + k] = 8'(wd >> (8 * k));
            bad_m[a + k] = 1'b0;
         end
      end
      if (!w || m) q.push_back(e);
   endtask

   task automatic idle();
      @(negedge clk);
      #1;
      req = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req   = 1'b0;
      q.delete();
      last_rd = 0;
      for (int i = 0; i < NB; i++) begin
         mem_m[i] = 8'h00;
         bad_m[i] = 1'b0;
      end
      repeat (3) begin
         @(negedge clk);
         #1;
         chk("busy_in_reset", 32'(busy), 32'h1);
      end
      rst_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         @(negedge clk);
         #1;
         chk("busy_window", 32'(busy), 32'(i < DEPTH));
         if (i == 3) begin
            req   = 1'b1;
            we    = 1'b1;
            size  = 2'd2;
            uns   = 1'b0;
            addr  = 32'h4;
            wdata = 32'hDEAD_BEEF;
         end
         if (i == 4) req = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] ad;
      logic [1:0]  sz;
      n_cmp   = 0;
      n_bad   = 0;
      ncyc    = 0;
      last_rd = 0;
      rst_n   = 1'b1;
      req     = 1'b0;
      we      = 1'b0;
      size    = 2'd0;
      uns     = 1'b0;
      addr    = 0;
      wdata   = 0;
      #3;
      do_reset();
      chk("reset_rdata", rdata, 32'h0);

      issue(0, 2'd2, 0, 32'h4, 0);
      issue(1, 2'd2, 0, 32'h8, 32'h1122_3344);
      issue(1, 2'd0, 0, 32'h9, 32'h0000_00AA);
      issue(0, 2'd2, 0, 32'h8, 0);
      issue(1, 2'd2, 0, 32'hC, 32'h80FF_7F01);
      issue(0, 2'd0, 0, 32'hF, 0);
      issue(0, 2'd0, 1, 32'hF, 0);
      issue(0, 2'd1, 0, 32'hE, 0);
      issue(0, 2'd1, 1, 32'hC, 0);
      issue(1, 2'd1, 0, 32'h11, 32'h1234);
      issue(0, 2'd2, 0, 32'h12, 0);
      issue(0, 2'd3, 0, 32'h0, 0);
      issue(0, 2'd2, 0, 32'h10, 0);
      issue(1, 2'd2, 0, 32'h40, 32'h5555_5555);
      issue(0, 2'd2, 0, 32'h0, 0);
      idle();

`ifdef DMEM_PARITY_EN
      issue(1, 2'd2, 0, 32'h20, 32'h0000_0001);
      idle();
      dut.par_q[8][0] = ~dut.par_q[8][0];
      bad_m[32] = 1'b1;
      issue(0, 2'd2, 0, 32'h20, 0);
      issue(0, 2'd0, 1, 32'h21, 0);
      idle();
`endif

      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 9) == 0) begin
            idle();
         end else begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            ad = $urandom;
            if ($urandom_range(0, 3) != 0 && sz != 2'd3)
               ad = ad & ~((32'd1 << sz) - 1);
            issue(1'($urandom), sz, 1'($urandom), ad, $urandom);
         end
      end
      idle();

      issue(1, 2'd2, 0, 32'h0, 32'hCAFE_F00D);
      issue(0, 2'd2, 0, 32'h0, 0);
      #2;
      do_reset();
      issue(0, 2'd2, 0, 32'h0, 0);
      issue(0, 2'd2, 0, 32'h3C, 0);
      repeat (3) idle();
      chk("drain", 32'(q.size()), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
